// File: rtl/round_sequencer.sv
// round_sequencer
//   Round master for the tug-of-war game. Walks the match through
//   WAIT -> DARK -> PLAY / FAKE / SPEED -> GLOAT, keeps the match score for
//   both players and parks in VICTORY once either player reaches
//   ROUNDS_TO_WIN. All timing is counted in slow `tick` enables.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   tick         in   slow enable, one clk cycle wide
//   win_a/win_b  in   player press / round-win pulses
//   rand_play    in   LFSR bit: start a real round from DARK
//   rand_fake    in   LFSR bit: start a fake round from DARK
//   rand_speed   in   LFSR bit: start a speed round from DARK
//   speed_exit   in   leave the speed-round score display early
//   new_game     in   leave VICTORY and restart the match
//   leds_on      out  LED enable
//   clear        out  clear the datapath round counters
//   led_control  out  LED mux select
//   fake         out  fake round active
//   speed_round  out  speed round active
//   score_a/b    out  match scores
//   victory      out  match over
module round_sequencer #(
  parameter int WAIT_TICKS    = 2,
  parameter int GLOAT_TICKS   = 2,
  parameter int FAKE_TICKS    = 4,
  parameter int SPEED_TICKS   = 8,
  parameter int SPEED_PTS     = 2,
  parameter int ROUNDS_TO_WIN = 3,
  parameter int SCORE_W       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               win_a,
  input  logic               win_b,
  input  logic               rand_play,
  input  logic               rand_fake,
  input  logic               rand_speed,
  input  logic               speed_exit,
  input  logic               new_game,
  output logic               leds_on,
  output logic               clear,
  output logic [2:0]         led_control,
  output logic               fake,
  output logic               speed_round,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               victory
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_WAIT       = 4'd1,
    S_DARK       = 4'd2,
    S_PLAY       = 4'd3,
    S_FAKE       = 4'd4,
    S_SPEED      = 4'd5,
    S_SPEED_SHOW = 4'd6,
    S_GLOAT      = 4'd7,
    S_VICTORY    = 4'd8
  } state_t;

  // The timer only has to reach N-1 for the longest timed state; in DARK and
  // VICTORY it free-runs and its value is never looked at, so wrapping is harmless.
  localparam int MAX_WG    = (WAIT_TICKS > GLOAT_TICKS) ? WAIT_TICKS : GLOAT_TICKS;
  localparam int MAX_FS    = (FAKE_TICKS > SPEED_TICKS) ? FAKE_TICKS : SPEED_TICKS;
  localparam int MAX_T     = (MAX_WG > MAX_FS) ? MAX_WG : MAX_FS;
  localparam int TIMER_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  state_t             state;
  logic [TIMER_W-1:0] timer;

  logic wait_done;
  logic gloat_done;
  logic fake_done;
  logic speed_done;
  logic match_won;

  // A timed state ends on the tick that would be its N-th one.
  assign wait_done  = tick && (timer == TIMER_W'(WAIT_TICKS - 1));
  assign gloat_done = tick && (timer == TIMER_W'(GLOAT_TICKS - 1));
  assign fake_done  = tick && (timer == TIMER_W'(FAKE_TICKS - 1));
  assign speed_done = tick && (timer == TIMER_W'(SPEED_TICKS - 1));
  assign match_won  = (int'(score_a) >= ROUNDS_TO_WIN) || (int'(score_b) >= ROUNDS_TO_WIN);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s, input int pts);
    int sum;
    sum = int'(s) + pts;
    if (sum > SCORE_MAX) sum = SCORE_MAX;
    return SCORE_W'(sum);
  endfunction

  // State, timer and scores. Every transition clears the timer; otherwise it
  // counts ticks. A press always wins over a tick arriving in the same cycle,
  // and in DARK/FAKE a lone press is a false start that scores for the opponent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RESET;
      timer   <= '0;
      score_a <= '0;
      score_b <= '0;
    end else begin
      if (tick) timer <= timer + TIMER_W'(1);
      case (state)
        S_RESET: begin
          state   <= S_WAIT;
          timer   <= '0;
          score_a <= '0;
          score_b <= '0;
        end
        S_WAIT: begin
          if (wait_done) begin
            state <= S_DARK;
            timer <= '0;
          end
        end
        S_DARK, S_FAKE: begin
          if (win_a && win_b) begin
            state <= S_GLOAT;
            timer <= '0;
          end else if (win_a) begin
            score_b <= sat_add(score_b, 1);
            state   <= S_GLOAT;
            timer   <= '0;
          end else if (win_b) begin
            score_a <= sat_add(score_a, 1);
            state   <= S_GLOAT;
            timer   <= '0;
          end else if (state == S_FAKE) begin
            if (fake_done) begin
              state <= S_DARK;
              timer <= '0;
            end
          end else if (tick && (rand_play || rand_fake || rand_speed)) begin
            timer <= '0;
            if (rand_play)      state <= S_PLAY;
            else if (rand_fake) state <= S_FAKE;
            else                state <= S_SPEED;
          end
        end
        S_PLAY: begin
          if (win_a || win_b) begin
            if (win_a && !win_b) score_a <= sat_add(score_a, 1);
            if (win_b && !win_a) score_b <= sat_add(score_b, 1);
            state <= S_GLOAT;
            timer <= '0;
          end
        end
        S_SPEED: begin
          if (win_a || win_b || speed_done) begin
            if (win_a && !win_b) score_a <= sat_add(score_a, SPEED_PTS);
            if (win_b && !win_a) score_b <= sat_add(score_b, SPEED_PTS);
            state <= S_SPEED_SHOW;
            timer <= '0;
          end
        end
        S_SPEED_SHOW: begin
          if (speed_exit || gloat_done) begin
            state <= S_GLOAT;
            timer <= '0;
          end
        end
        S_GLOAT: begin
          if (gloat_done) begin
            state <= match_won ? S_VICTORY : S_WAIT;
            timer <= '0;
          end
        end
        S_VICTORY: begin
          if (new_game) begin
            state   <= S_RESET;
            timer   <= '0;
            score_a <= '0;
            score_b <= '0;
          end
        end
        default: begin
          state   <= S_RESET;
          timer   <= '0;
          score_a <= '0;
          score_b <= '0;
        end
      endcase
    end
  end

  // Moore decode straight from the state register, so outputs are already
  // correct in the first cycle of each state.
  always_comb begin
    leds_on     = 1'b1;
    clear       = 1'b1;
    led_control = 3'b001;
    fake        = 1'b0;
    speed_round = 1'b0;
    victory     = 1'b0;
    case (state)
      S_RESET:      led_control = 3'b001;
      S_WAIT:       led_control = 3'b010;
      S_DARK: begin
        leds_on     = 1'b0;
        clear       = 1'b0;
        led_control = 3'b000;
      end
      S_PLAY: begin
        clear       = 1'b0;
        led_control = 3'b011;
      end
      S_FAKE: begin
        clear       = 1'b0;
        led_control = 3'b100;
        fake        = 1'b1;
      end
      S_SPEED: begin
        led_control = 3'b110;
        speed_round = 1'b1;
      end
      S_SPEED_SHOW: led_control = 3'b110;
      S_GLOAT:      led_control = 3'b011;
      S_VICTORY: begin
        led_control = 3'b111;
        victory     = 1'b1;
      end
      default:      led_control = 3'b001;
    endcase
  end

endmodule
